pkt_ingress_arbiter: RTL and testbench
======================================

# pkt_ingress_arbiter

Packet-atomic round-robin arbiter that shares the single AXI4-Stream ingress of `packet_buffer` between `NUM_SRC` capture sources. Each source presents complete framed packets: the header beat(s) followed by the payload, terminated by `tlast`. The arbiter locks onto one source from the first accepted beat to its `tlast`, then re-arbitrates. A 2-entry output FIFO decouples downstream backpressure. The block sits directly in front of `packet_buffer.tdata_i/tvalid_i/tlast_i/tready_o`.

## Interface
- `AXI_WIDTH`, 64, data width of every stream; multiple of 8.
- `NUM_SRC`, 4, number of requesters; range 2..16.
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `s_tdata_i` in `NUM_SRC` x `AXI_WIDTH`: per-source beat data.
- `s_tvalid_i` in `NUM_SRC`: per-source beat valid.
- `s_tlast_i` in `NUM_SRC`: per-source last beat of packet.
- `s_tready_o` out `NUM_SRC`: per-source ready; at most one bit high in any cycle.
- `m_tdata_o` out `AXI_WIDTH`: data to `packet_buffer`.
- `m_tvalid_o` out 1: output valid.
- `m_tlast_o` out 1: output last.
- `m_tready_i` in 1: downstream ready.
- `grant_o` out `NUM_SRC`: one-hot current owner; all zero in IDLE.
- `busy_o` out 1: high in LOCKED.

## Operation
- States: IDLE, LOCKED.
- IDLE: if any `s_tvalid_i` is high, select the first valid source searching upward from `last_grant+1`, wrapping modulo `NUM_SRC`. Register it as `grant`, set `last_grant` to it, and enter LOCKED next cycle. No `s_tready_o` is asserted while in IDLE.
- LOCKED: `s_tready_o[grant] = (fifo_count != 2)`; all other ready bits are 0. A beat is accepted when valid and ready are both high. It is pushed into the FIFO as {tdata, tlast}.
- An accepted beat with `tlast = 1` returns the arbiter to IDLE next cycle. `grant_o` clears in the same transition.
- A granted source deasserting `tvalid` mid-packet keeps the lock indefinitely. Packets are never interleaved.
- FIFO pops when `m_tvalid_o && m_tready_i`. Push and pop in the same cycle at count 2 is not possible because ready is low. At count 1, push and pop together leave count 1.
- `m_tvalid_o = (fifo_count != 0)`. `m_tdata_o` and `m_tlast_o` come from the FIFO head and are stable while valid and not ready (AXI rule).
- `fifo_count` is 2 bits wide. `grant` and `last_grant` are `$clog2(NUM_SRC)` bits wide.

## Timing
- Reset values:
  - `s_tready_o = 0`, `m_tvalid_o = 0`, `m_tlast_o = 0`, `m_tdata_o = 0`, `grant_o = 0`, `busy_o = 0`.
  - FIFO empty, state IDLE.
  - `last_grant = NUM_SRC-1`, so source 0 has first priority.
- Grant latency: valid seen in IDLE at cycle N gives `s_tready_o` at N+1 (if the FIFO is not full).
- Data latency: beat accepted at cycle N appears on `m_*` at N+1 when the FIFO was empty.
- Throughput: 1 beat/cycle within a packet while `m_tready_i = 1`. There is exactly 1 idle input cycle per packet boundary (the IDLE arbitration cycle).
- Reset mid-packet: FIFO is flushed, and a truncated packet is dropped without a `tlast`. `packet_buffer` shares `rst_i`.
- Single-beat packet (`tlast` on the first beat) takes LOCKED for exactly 1 cycle.

## Configuration
- `PKT_ARB_STATS_EN`:
  - Defined: adds output `pkt_count_o` (`NUM_SRC` x 32). Entry i increments on each accepted `tlast` beat from source i and saturates at 0xFFFFFFFF. All entries reset to 0 on `rst_i`.
  - Undefined: the port and counters are absent; all other behaviour is identical.

## Test plan
- **Single source:** src 0 sends a 3-beat packet with `m_tready_i = 1`.
  - `s_tready_o[0]` high 1 cycle after `tvalid`.
  - 3 beats appear on `m_*` with 1-cycle lag, `m_tlast_o` on beat 3.
  - `grant_o` goes 0001 then 0000.
- **Round-robin fairness:** all 4 sources continuously valid with 2-beat packets.
  - Grant order 0,1,2,3,0.
  - No interleaving: `m_tdata_o` carries the per-source tag pattern in contiguous pairs.
- **Backpressure:** hold `m_tready_i = 0` during a 5-beat packet.
  - FIFO fills to 2, then `s_tready_o` drops; data is held stable.
  - Release: all 5 beats delivered in order, none lost or duplicated.
- **Mid-packet stall:** src 1 drops `tvalid` for 10 cycles mid-packet while src 2 is valid.
  - `grant_o` stays 0010 and src 2 `tready` stays 0 until src 1's `tlast`.
- **Reset mid-packet:** assert `rst_i` for 1 cycle during beat 2 of 4.
  - Next cycle all outputs are 0 and the FIFO is empty.
  - With srcs 0 and 3 valid afterwards, the next grant is src 0.
- **Stats (`PKT_ARB_STATS_EN`):** sources 0/2 send 3/1 packets.
  - `pkt_count_o` = {0, 1, 0, 3} (src 3..0) after completion.

Source files
------------

// File: rtl/pkt_ingress_arbiter.sv
// Packet-atomic round-robin arbiter feeding a single AXI4-Stream ingress through a 2-entry FIFO.
// Optional per-source packet counters are enabled with the PKT_ARB_STATS_EN macro.
module pkt_ingress_arbiter #(
    parameter int AXI_WIDTH = 64,
    parameter int NUM_SRC   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_SRC-1:0][AXI_WIDTH-1:0]    s_tdata_i,
    input  logic [NUM_SRC-1:0]                   s_tvalid_i,
    input  logic [NUM_SRC-1:0]                   s_tlast_i,
    output logic [NUM_SRC-1:0]                   s_tready_o,
    output logic [AXI_WIDTH-1:0]                 m_tdata_o,
    output logic                                 m_tvalid_o,
    output logic                                 m_tlast_o,
    input  logic                                 m_tready_i,
    output logic [NUM_SRC-1:0]                   grant_o,
    output logic                                 busy_o
`ifdef PKT_ARB_STATS_EN
    ,
    output logic [NUM_SRC-1:0][31:0]             pkt_count_o
`endif
);

    localparam int GW = $clog2(NUM_SRC);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [NUM_SRC-1:0] to_onehot(input logic [GW-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [GW-1:0]          grant_r, grant_nxt_s;
    logic [GW-1:0]          last_grant_r, last_grant_nxt_s;
    logic [GW-1:0]          pick_s;
    logic                   pick_found_s;
    logic [1:0]             count_r, count_nxt_s;
    logic [AXI_WIDTH-1:0]   head_data_r, tail_data_r;
    logic                   head_last_r, tail_last_r;
    logic                   valid_r;
    logic                   push_s, pop_s;
    logic [AXI_WIDTH-1:0]   in_data_s;
    logic                   in_last_s;

    // Ready is only ever high for the owner, so any ready&valid overlap is the owner's beat.
    assign push_s     = |(s_tready_o & s_tvalid_i);
    assign pop_s      = valid_r & m_tready_i;
    assign in_data_s  = s_tdata_i[grant_r];
    assign in_last_s  = s_tlast_i[grant_r];
    assign m_tvalid_o = valid_r;
    assign m_tdata_o  = head_data_r;
    assign m_tlast_o  = head_last_r;

    // Round-robin search upward from the source after the previous winner.
    always_comb begin
        logic [GW-1:0] cand;
        pick_s       = last_grant_r;
        pick_found_s = 1'b0;
        cand         = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = GW'((int'(last_grant_r) + i) % NUM_SRC);
            if (!pick_found_s && s_tvalid_i[cand]) begin
                pick_s       = cand;
                pick_found_s = 1'b1;
            end else begin
                pick_s       = pick_s;
            end
        end
    end

    // Arbitration state machine: lock on a source until its tlast beat is accepted.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s      = ST_LOCKED;
                    grant_nxt_s      = pick_s;
                    last_grant_nxt_s = pick_s;
                end else begin
                    state_nxt_s      = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (push_s && in_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FIFO occupancy; push and pop together leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Control registers; outputs are precomputed from next-state so they come straight from flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= GW'(NUM_SRC - 1);
            count_r      <= 2'd0;
            valid_r      <= 1'b0;
            s_tready_o   <= '0;
            grant_o      <= '0;
            busy_o       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            count_r      <= count_nxt_s;
            valid_r      <= (count_nxt_s != 2'd0);
            s_tready_o   <= ((state_nxt_s == ST_LOCKED) && (count_nxt_s != 2'd2)) ?
                            to_onehot(grant_nxt_s) : '0;
            grant_o      <= (state_nxt_s == ST_LOCKED) ? to_onehot(grant_nxt_s) : '0;
            busy_o       <= (state_nxt_s == ST_LOCKED);
        end
    end

    // Two-entry shifting FIFO: the head register drives the output directly and only moves on pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_data_r <= '0;
            head_last_r <= 1'b0;
            tail_data_r <= '0;
            tail_last_r <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_data_r <= in_data_s;
                        head_last_r <= in_last_s;
                    end else begin
                        tail_data_r <= in_data_s;
                        tail_last_r <= in_last_s;
                    end
                end
                2'b01: begin
                    head_data_r <= tail_data_r;
                    head_last_r <= tail_last_r;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_data_r <= in_data_s;
                        head_last_r <= in_last_s;
                    end else begin
                        head_data_r <= tail_data_r;
                        head_last_r <= tail_last_r;
                        tail_data_r <= in_data_s;
                        tail_last_r <= in_last_s;
                    end
                end
                default: begin
                    head_data_r <= head_data_r;
                    head_last_r <= head_last_r;
                end
            endcase
        end
    end

`ifdef PKT_ARB_STATS_EN
    logic [31:0] pkt_count_r [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_stats
        // Saturating count of completed packets from source g.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pkt_count_r[g] <= 32'd0;
            end else if (push_s && in_last_s && (grant_r == GW'(g)) &&
                         (pkt_count_r[g] != 32'hFFFF_FFFF)) begin
                pkt_count_r[g] <= pkt_count_r[g] + 32'd1;
            end else begin
                pkt_count_r[g] <= pkt_count_r[g];
            end
        end
        assign pkt_count_o[g] = pkt_count_r[g];
    end
`endif

endmodule

// File: tb/tb_pkt_ingress_arbiter.sv
// Self-checking bench for pkt_ingress_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model. Stats checks are built when PKT_ARB_STATS_EN is defined.
module tb_pkt_ingress_arbiter;
    localparam int W = 64;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [N-1:0][W-1:0]  s_tdata;
    logic [N-1:0]         s_tvalid, s_tlast, s_tready;
    logic [W-1:0]         m_tdata;
    logic                 m_tvalid, m_tlast, m_tready;
    logic [N-1:0]         grant;
    logic                 busy;
`ifdef PKT_ARB_STATS_EN
    logic [N-1:0][31:0]   pkt_count;
`endif

    pkt_ingress_arbiter #(.AXI_WIDTH(W), .NUM_SRC(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
        .grant_o(grant), .busy_o(busy)
`ifdef PKT_ARB_STATS_EN
        , .pkt_count_o(pkt_count)
`endif
    );

    int total = 0;
    int bad = 0;

    // Source state: each source walks through packets of plen beats; en gates its tvalid.
    logic [N-1:0] en;
    int           plen [N];
    int           pcnt [N];
    int           bidx [N];
    bit           rand_len;
    logic [W:0]   obs [$];

    function automatic logic [W-1:0] mk(input int src, input int pkt, input int beat);
        return {4'hA, 4'(src), 24'(pkt), 32'(beat)};
    endfunction

    // Drive the sources at the current falling edge, log output beats, advance one clock.
    task automatic step();
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = en[i];
            s_tdata[i]  = mk(i, pcnt[i], bidx[i]);
            s_tlast[i]  = (bidx[i] == plen[i] - 1);
        end
        if (m_tvalid && m_tready) obs.push_back({m_tlast, m_tdata});
        acc = s_tready & s_tvalid;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (bidx[i] == plen[i] - 1) begin
                    bidx[i] = 0;
                    pcnt[i]++;
                    if (rand_len) plen[i] = $urandom_range(1, 5);
                end else begin
                    bidx[i]++;
                end
            end
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            pcnt[i] = 0;
            bidx[i] = 0;
        end
        obs.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = '0;
        step();
        rst = 1'b0;
        clear_sources();
        for (int i = 0; i < N; i++) plen[i] = 2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 4'hF;
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if ({s_tready, grant, busy, m_tvalid, m_tlast, m_tdata} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got rdy=%b gnt=%b busy=%b mv=%b ml=%b md=%h want all zero",
                         s_tready, grant, busy, m_tvalid, m_tlast, m_tdata);
            end
        end
        rst = 1'b0;
        en  = '0;
        clear_sources();
    endtask

    task automatic test_single_source();
        do_reset();
        plen[0]  = 3;
        m_tready = 1'b1;
        en       = 4'b0001;
        step();
        total++;
        if ({s_tready, grant, busy, m_tvalid} !== {4'b0001, 4'b0001, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL single_grant: got rdy=%b gnt=%b busy=%b mv=%b want 0001 0001 1 0",
                     s_tready, grant, busy, m_tvalid);
        end
        for (int b = 0; b < 3; b++) begin
            step();
            total++;
            if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, (b == 2), mk(0, 0, b)}) begin
                bad++;
                $display("FAIL single_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                         b, m_tvalid, m_tlast, m_tdata, (b == 2), mk(0, 0, b));
            end
            total++;
            if (grant !== ((b == 2) ? 4'b0000 : 4'b0001)) begin
                bad++;
                $display("FAIL single_grant_beat%0d: got %b", b, grant);
            end
        end
        en = '0;
        step();
        total++;
        if ({m_tvalid, s_tready, grant, busy} !== 10'd0) begin
            bad++;
            $display("FAIL single_drain: got mv=%b rdy=%b gnt=%b busy=%b want all zero",
                     m_tvalid, s_tready, grant, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] gseq [$];
        logic [N-1:0] prevg;
        do_reset();
        m_tready = 1'b1;
        en       = 4'hF;
        prevg    = '0;
        for (int k = 0; k < 18; k++) begin
            step();
            if (grant != '0 && grant != prevg) gseq.push_back(grant);
            prevg = grant;
        end
        en = '0;
        total++;
        if (gseq.size() < 5 || obs.size() < 10) begin
            bad++;
            $display("FAIL rr_progress: got grants=%0d beats=%0d want >=5 >=10", gseq.size(), obs.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (gseq[k] !== N'(32'd1 << (k % N))) begin
                    bad++;
                    $display("FAIL rr_order%0d: got %b want %b", k, gseq[k], N'(32'd1 << (k % N)));
                end
            end
            for (int k = 0; k < 10; k++) begin
                total++;
                if (obs[k] !== {(k % 2 == 1), mk((k / 2) % N, (k / 2) / N, k % 2)}) begin
                    bad++;
                    $display("FAIL rr_data%0d: got %h want %h", k, obs[k],
                             {(k % 2 == 1), mk((k / 2) % N, (k / 2) / N, k % 2)});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        plen[0]  = 5;
        m_tready = 1'b0;
        en       = 4'b0001;
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({s_tready, grant, m_tvalid, m_tlast, m_tdata} !==
                {4'b0000, 4'b0001, 1'b1, 1'b0, mk(0, 0, 0)}) begin
                bad++;
                $display("FAIL bp_hold%0d: got rdy=%b gnt=%b mv=%b ml=%b md=%h want 0000 0001 1 0 %h",
                         k, s_tready, grant, m_tvalid, m_tlast, m_tdata, mk(0, 0, 0));
            end
            step();
        end
        m_tready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            en = {3'b000, (pcnt[0] == 0)};
            step();
        end
        total++;
        if (obs.size() != 5) begin
            bad++;
            $display("FAIL bp_count: got %0d beats want 5", obs.size());
        end else begin
            for (int b = 0; b < 5; b++) begin
                total++;
                if (obs[b] !== {(b == 4), mk(0, 0, b)}) begin
                    bad++;
                    $display("FAIL bp_beat%0d: got %h want %h", b, obs[b], {(b == 4), mk(0, 0, b)});
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        plen[1]  = 4;
        plen[2]  = 2;
        m_tready = 1'b1;
        en       = 4'b0110;
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 10; k++) begin
            en = 4'b0100;
            step();
            total++;
            if ({grant, s_tready[2], busy} !== {4'b0010, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL stall_lock%0d: got gnt=%b rdy2=%b busy=%b want 0010 0 1",
                         k, grant, s_tready[2], busy);
            end
        end
        for (int k = 0; k < 12; k++) begin
            en = {1'b0, (pcnt[2] == 0), (pcnt[1] == 0), 1'b0};
            step();
        end
        total++;
        if (obs.size() != 6) begin
            bad++;
            $display("FAIL stall_count: got %0d beats want 6", obs.size());
        end else begin
            for (int b = 0; b < 6; b++) begin
                total++;
                if (obs[b] !== ((b < 4) ? {(b == 3), mk(1, 0, b)} : {(b == 5), mk(2, 0, b - 4)})) begin
                    bad++;
                    $display("FAIL stall_beat%0d: got %h", b, obs[b]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        plen[0]  = 4;
        m_tready = 1'b0;
        en       = 4'b0001;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({s_tready, grant, busy, m_tvalid, m_tlast, m_tdata} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got rdy=%b gnt=%b busy=%b mv=%b md=%h want all zero",
                     s_tready, grant, busy, m_tvalid, m_tdata);
        end
        clear_sources();
        m_tready = 1'b1;
        en       = 4'b1001;
        step();
        total++;
        if ({grant, s_tready} !== {4'b0001, 4'b0001}) begin
            bad++;
            $display("FAIL midrst_regrant: got gnt=%b rdy=%b want 0001 0001", grant, s_tready);
        end
        en = '0;
    endtask

`ifdef PKT_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        m_tready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            en = {1'b0, (pcnt[2] < 1), 1'b0, (pcnt[0] < 3)};
            step();
        end
        total++;
        if (pkt_count !== {32'd0, 32'd1, 32'd0, 32'd3}) begin
            bad++;
            $display("FAIL stats_counts: got %h want 3..0 = 0,1,0,3", pkt_count);
        end
    endtask
`endif

    // Randomized traffic checked cycle by cycle against an owner/queue model of the arbiter.
    task automatic test_random();
        int           own;
        int           lastg;
        logic [W:0]   mq [$];
        logic [W:0]   mbeat;
        logic         macc, mpop, lst;
        logic [N-1:0] exp_rdy, exp_gnt;
        do_reset();
        rand_len = 1'b1;
        for (int i = 0; i < N; i++) plen[i] = $urandom_range(1, 5);
        own   = -1;
        lastg = N - 1;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
            m_tready = ($urandom_range(0, 3) != 0);
            macc  = (own >= 0) && en[own] && (mq.size() < 2);
            mpop  = (mq.size() > 0) && m_tready;
            lst   = (own >= 0) && (bidx[own] == plen[own] - 1);
            mbeat = (own >= 0) ? {lst, mk(own, pcnt[own], bidx[own])} : '0;
            step();
            if (mpop) void'(mq.pop_front());
            if (macc) mq.push_back(mbeat);
            if (own < 0) begin
                for (int j = 1; j <= N; j++) begin
                    if (own < 0 && en[(lastg + j) % N]) own = (lastg + j) % N;
                end
                if (own >= 0) lastg = own;
            end else if (macc && lst) begin
                own = -1;
            end
            exp_gnt = (own >= 0) ? N'(32'd1 << own) : '0;
            exp_rdy = (mq.size() < 2) ? exp_gnt : '0;
            total++;
            if ({s_tready, grant, busy, m_tvalid} !== {exp_rdy, exp_gnt, (own >= 0), (mq.size() != 0)}) begin
                bad++;
                $display("FAIL rand_ctrl@%0d: got rdy=%b gnt=%b busy=%b mv=%b want %b %b %b %b", k,
                         s_tready, grant, busy, m_tvalid, exp_rdy, exp_gnt, (own >= 0), (mq.size() != 0));
            end
            if (mq.size() != 0) begin
                total++;
                if ({m_tlast, m_tdata} !== mq[0]) begin
                    bad++;
                    $display("FAIL rand_data@%0d: got %h want %h", k, {m_tlast, m_tdata}, mq[0]);
                end
            end
        end
        rand_len = 1'b0;
        en       = '0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = '0;
        m_tready = 1'b1;
        rand_len = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        for (int i = 0; i < N; i++) plen[i] = 2;
        clear_sources();
        @(negedge clk);
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_reset_mid_packet();
`ifdef PKT_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
